// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one access per request, sequenced IDLE -> SETUP -> ACCESS -> RECOVER.
// Optional write-verify readback is enabled by defining SRAM_CTRL_WRVERIFY_EN.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 17,
  parameter int HOLD_CYCLES   = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     rw,
  input  logic [RAM_ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     ready,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rdata_valid,
  output logic                     verify_err,
  output logic                     CE,
  output logic                     OE,
  output logic                     WE,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [WIDTH-1:0]         input_data,
  input  logic [WIDTH-1:0]         stackData
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] count;
  logic       is_write;

  assign ready = (state == IDLE);

`ifdef SRAM_CTRL_WRVERIFY_EN
  logic verify_phase;
  logic verify_err_q;

  assign verify_err = verify_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 4'd0;
      is_write     <= 1'b0;
      verify_phase <= 1'b0;
      CE           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      address      <= '0;
      input_data   <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            address    <= addr;
            input_data <= wdata;
            is_write   <= rw;
            state      <= SETUP;
          end
        end
        SETUP: begin
          count <= 4'd0;
          CE    <= 1'b0;
          OE    <= is_write;
          WE    <= ~is_write;
          state <= ACCESS;
        end
        ACCESS: begin
          if (count == LAST) begin
            CE    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            state <= RECOVER;
            if (!is_write) begin
              // The readback pass only compares; host-visible read data is untouched.
              if (verify_phase) begin
                if (stackData != input_data) verify_err_q <= 1'b1;
              end else begin
                rdata       <= stackData;
                rdata_valid <= 1'b1;
              end
            end
          end else begin
            count <= count + 4'd1;
          end
        end
        RECOVER: begin
          if (is_write) begin
            is_write     <= 1'b0;
            verify_phase <= 1'b1;
            state        <= SETUP;
          end else begin
            verify_phase <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign verify_err = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 4'd0;
      is_write    <= 1'b0;
      CE          <= 1'b1;
      OE          <= 1'b1;
      WE          <= 1'b1;
      address     <= '0;
      input_data  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            address    <= addr;
            input_data <= wdata;
            is_write   <= rw;
            state      <= SETUP;
          end
        end
        SETUP: begin
          count <= 4'd0;
          CE    <= 1'b0;
          OE    <= is_write;
          WE    <= ~is_write;
          state <= ACCESS;
        end
        ACCESS: begin
          // Strobes release on the same edge that ends the hold window.
          if (count == LAST) begin
            CE    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            state <= RECOVER;
            if (!is_write) begin
              rdata       <= stackData;
              rdata_valid <= 1'b1;
            end
          end else begin
            count <= count + 4'd1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural asynchronous SRAM model attached.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int W    = 16;
  localparam int AB   = 17;
  localparam int HOLD = 7;
  localparam int LAT  = HOLD + 3;
`ifdef SRAM_CTRL_WRVERIFY_EN
  localparam int WLAT = 2 * HOLD + 5;
  localparam int OE_W = HOLD;
`else
  localparam int WLAT = LAT;
  localparam int OE_W = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          rw = 1'b0;
  logic [AB-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          ready, rdata_valid, verify_err, CE, OE, WE;
  logic [W-1:0]  rdata, input_data, stackData;
  logic [AB-1:0] address;

  logic [W-1:0]  mem [0:(1<<AB)-1];
  logic          force_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WIDTH(W), .RAM_ADDR_BITS(AB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .verify_err(verify_err),
    .CE(CE), .OE(OE), .WE(WE), .address(address), .input_data(input_data),
    .stackData(stackData)
  );

  always @(posedge clk) if (!CE && !WE) mem[address] <= input_data;

  always_comb begin
    stackData = '0;
    if (!force_zero && !CE && !OE) stackData = mem[address];
  end

  // Issues one request and records strobe/handshake observations until ready returns.
  task automatic run_access(input logic w, input logic [AB-1:0] a, input logic [W-1:0] d,
                            output int ready_cyc, output int we_low, output int oe_low,
                            output int valid_cyc, output int valid_cnt, output int proto);
    ready_cyc = -1; we_low = 0; oe_low = 0; valid_cyc = -1; valid_cnt = 0; proto = 0;
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (!WE) we_low++;
      if (!OE) oe_low++;
      if (!OE && !WE) proto++;
      if (!CE && (address !== a || input_data !== d)) proto++;
      if (rdata_valid) begin valid_cnt++; valid_cyc = c; end
      if (ready) begin ready_cyc = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
    checks++; if ({CE, OE, WE} !== 3'b111) begin errors++; $display("FAIL reset_strobes got=%b want=111", {CE, OE, WE}); end
    checks++; if (address !== '0) begin errors++; $display("FAIL reset_address got=%h want=0", address); end
    checks++; if (input_data !== '0) begin errors++; $display("FAIL reset_input_data got=%h want=0", input_data); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got=%b want=0", rdata_valid); end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL reset_verify_err got=%b want=0", verify_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int rc, wl, ol, vc, vn, pe;
    run_access(1'b1, 17'h00012, 16'hBEEF, rc, wl, ol, vc, vn, pe);
    checks++; if (wl != HOLD) begin errors++; $display("FAIL write_we_low got=%0d want=%0d", wl, HOLD); end
    checks++; if (ol != OE_W) begin errors++; $display("FAIL write_oe_low got=%0d want=%0d", ol, OE_W); end
    checks++; if (rc != WLAT) begin errors++; $display("FAIL write_latency got=%0d want=%0d", rc, WLAT); end
    checks++; if (vn != 0) begin errors++; $display("FAIL write_valid_pulses got=%0d want=0", vn); end
    checks++; if (pe != 0) begin errors++; $display("FAIL write_protocol got=%0d want=0", pe); end
    checks++; if (mem[17'h00012] !== 16'hBEEF) begin errors++; $display("FAIL write_mem got=%h want=beef", mem[17'h00012]); end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL write_verify_ok got=%b want=0", verify_err); end
  endtask

  task automatic test_read();
    int rc, wl, ol, vc, vn, pe;
    run_access(1'b0, 17'h00012, 16'h0000, rc, wl, ol, vc, vn, pe);
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata got=%h want=beef", rdata); end
    checks++; if (vn != 1) begin errors++; $display("FAIL read_valid_pulses got=%0d want=1", vn); end
    checks++; if (vc != HOLD + 2) begin errors++; $display("FAIL read_valid_cycle got=%0d want=%0d", vc, HOLD + 2); end
    checks++; if (rc != LAT) begin errors++; $display("FAIL read_latency got=%0d want=%0d", rc, LAT); end
    checks++; if (wl != 0) begin errors++; $display("FAIL read_we_low got=%0d want=0", wl); end
    checks++; if (ol != HOLD) begin errors++; $display("FAIL read_oe_low got=%0d want=%0d", ol, HOLD); end
    checks++; if (pe != 0) begin errors++; $display("FAIL read_protocol got=%0d want=0", pe); end
  endtask

  task automatic test_reset_mid_write();
    int bad = 0;
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 17'h00040; wdata = 16'h1234;
    @(negedge clk);
    req = 1'b0;
    // Cycle 1 is SETUP; the ACCESS cycle with counter==3 is cycle 5.
    repeat (4) @(negedge clk);
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL abort_in_access got WE=%b want=0", WE); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({CE, OE, WE} !== 3'b111) begin errors++; $display("FAIL abort_strobes got=%b want=111", {CE, OE, WE}); end
    checks++; if (address !== '0) begin errors++; $display("FAIL abort_address got=%h want=0", address); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", ready); end
    for (int c = 0; c < 12; c++) begin
      if (rdata_valid || !WE || !CE) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got=%0d want=0", bad); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL abort_rdata got=%h want=0", rdata); end
  endtask

  task automatic test_back_to_back();
    int last_ready = -1, accepts = 0, reads = 0, want_gap = 0;
    logic next_w = 1'b1;
    logic [W-1:0] last_w = '0;
    req = 1'b1; addr = 17'h1FFFF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (rdata_valid) begin
        reads++;
        checks++; if (rdata !== last_w) begin errors++; $display("FAIL b2b_rdata got=%h want=%h", rdata, last_w); end
      end
      if (ready) begin
        if (accepts == 4) begin req = 1'b0; break; end
        if (last_ready >= 0) begin
          checks++; if (c - last_ready != want_gap) begin errors++; $display("FAIL b2b_period got=%0d want=%0d", c - last_ready, want_gap); end
        end
        last_ready = c;
        rw = next_w;
        if (next_w) begin
          wdata = (accepts == 0) ? 16'hFFFF : 16'h5555;
          last_w = wdata;
          want_gap = WLAT;
        end else begin
          want_gap = LAT;
        end
        next_w = ~next_w;
        accepts++;
      end
    end
    req = 1'b0;
    checks++; if (accepts != 4) begin errors++; $display("FAIL b2b_accepts got=%0d want=4", accepts); end
    checks++; if (reads != 2) begin errors++; $display("FAIL b2b_reads got=%0d want=2", reads); end
  endtask

  task automatic test_verify();
    int rc, wl, ol, vc, vn, pe;
    force_zero = 1'b1;
    run_access(1'b1, 17'h00077, 16'h5A5A, rc, wl, ol, vc, vn, pe);
    force_zero = 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_set got=%b want=1", verify_err); end
`else
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_off got=%b want=0", verify_err); end
`endif
    checks++; if (rc != WLAT) begin errors++; $display("FAIL verify_latency got=%0d want=%0d", rc, WLAT); end
    checks++; if (vn != 0) begin errors++; $display("FAIL verify_valid_pulses got=%0d want=0", vn); end
    run_access(1'b0, 17'h00077, 16'h0000, rc, wl, ol, vc, vn, pe);
    checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL verify_readback got=%h want=5a5a", rdata); end
`ifdef SRAM_CTRL_WRVERIFY_EN
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_sticky got=%b want=1", verify_err); end
`else
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_stays_off got=%b want=0", verify_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_mid_write();
    test_back_to_back();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
